// File: rtl/vga_timing_output.sv
// ---------------------------------------------------------------------------
// vga_timing_output
//
// 640x480@60 style VGA timing generator and colour output stage.
//
// A free-running x/y raster counter issues pixel coordinates to the upstream
// colour source. Colour for a coordinate comes back on pixel_in PIPE_DELAY
// cycles later. The sync and active flags decoded from x/y are delayed by the
// same PIPE_DELAY stages and then registered together with the colour, so
// hsync, vsync, blank_n and red/green/blue all leave the block
// PIPE_DELAY+1 cycles after the coordinate they belong to.
//
// Optional feature: define VGA_TEST_PATTERN_EN to add a test_mode input that
// replaces pixel_in with eight 80-pixel vertical colour bars.
//
// Ports
//   clk         pixel clock, all state changes on its rising edge
//   reset       asynchronous active-low reset
//   test_mode   (VGA_TEST_PATTERN_EN only) 1 = colour bars, 0 = pixel_in
//   pixel_in    {R,G,B} colour for the coordinate issued PIPE_DELAY cycles ago
//   x, y        current raster coordinate, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   hsync       active-low horizontal sync, aligned with colour
//   vsync       active-low vertical sync, aligned with colour
//   blank_n     high while the aligned colour is in the active region
//   red/green/blue  DAC channels, forced to 0 outside the active region
//   frame_start combinational pulse while x=0 and y=0
// ---------------------------------------------------------------------------
module vga_timing_output #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned PIPE_DELAY = 1,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                  test_mode,
`endif
  input  logic [DATA_WIDTH-1:0] pixel_in,
  output logic [9:0]            x,
  output logic [9:0]            y,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  blank_n,
  output logic [7:0]            red,
  output logic [7:0]            green,
  output logic [7:0]            blue,
  output logic                  frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Coordinates are 10 bits wide; any raster that does not fit is refused.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_output: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (PIPE_DELAY > 3) begin : g_bad_delay
    $error("vga_timing_output: PIPE_DELAY must be 0..3");
  end
  if (DATA_WIDTH < 24) begin : g_bad_width
    $error("vga_timing_output: DATA_WIDTH must hold 24-bit RGB");
  end

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Everything that has to stay aligned with pixel_in travels in one word.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
`ifdef VGA_TEST_PATTERN_EN
    logic [9:0] x;
`endif
  } tap_t;

  // Idle tap: syncs deasserted (high), not active.
  function automatic tap_t idle_tap();
    tap_t t;
    t     = '0;
    t.hs  = 1'b1;
    t.vs  = 1'b1;
    return t;
  endfunction

`ifdef VGA_TEST_PATTERN_EN
  // Bar index is x/80; written as a compare chain to avoid a divider.
  function automatic logic [23:0] bar_colour(input logic [9:0] bx);
    logic [23:0] c;
    if      (bx < 10'd80)  c = 24'hFFFFFF;  // white
    else if (bx < 10'd160) c = 24'hFFFF00;  // yellow
    else if (bx < 10'd240) c = 24'h00FFFF;  // cyan
    else if (bx < 10'd320) c = 24'h00FF00;  // green
    else if (bx < 10'd400) c = 24'hFF00FF;  // magenta
    else if (bx < 10'd480) c = 24'hFF0000;  // red
    else if (bx < 10'd560) c = 24'h0000FF;  // blue
    else                   c = 24'h000000;  // black
    return c;
  endfunction
`endif

  // ---- raster counter ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (x == H_LAST) begin
      x <= '0;
      y <= (y == V_LAST) ? 10'd0 : y + 10'd1;
    end else begin
      x <= x + 10'd1;
    end
  end

  // Gated by reset so no start pulse is seen while the raster is held.
  assign frame_start = reset && (x == 10'd0) && (y == 10'd0);

  // ---- stage p0: raw decode from x/y ----
  tap_t tap_p0;
  tap_t tap_p1;

  always_comb begin
    tap_p0     = idle_tap();
    tap_p0.hs  = !((x >= HS_START) && (x < HS_END));
    tap_p0.vs  = !((y >= VS_START) && (y < VS_END));
    tap_p0.act = (x < H_ACT) && (y < V_ACT);
`ifdef VGA_TEST_PATTERN_EN
    tap_p0.x   = x;
`endif
  end

  // ---- stage p1: PIPE_DELAY-deep delay to line up with pixel_in ----
  if (PIPE_DELAY == 0) begin : g_no_dly
    assign tap_p1 = tap_p0;
  end else begin : g_dly
    tap_t sr [PIPE_DELAY];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < PIPE_DELAY; i++) sr[i] <= idle_tap();
      end else begin
        sr[0] <= tap_p0;
        for (int i = 1; i < PIPE_DELAY; i++) sr[i] <= sr[i-1];
      end
    end

    assign tap_p1 = sr[PIPE_DELAY-1];
  end

  logic [23:0] colour_p1;

  always_comb begin
    colour_p1 = 24'h000000;
    if (tap_p1.act) begin
      colour_p1 = pixel_in[23:0];
`ifdef VGA_TEST_PATTERN_EN
      if (test_mode) colour_p1 = bar_colour(tap_p1.x);
`endif
    end
  end

  // ---- output register: sync, blank and colour share one stage ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      blank_n <= 1'b0;
      red     <= '0;
      green   <= '0;
      blue    <= '0;
    end else begin
      hsync               <= tap_p1.hs;
      vsync               <= tap_p1.vs;
      blank_n             <= tap_p1.act;
      {red, green, blue}  <= colour_p1;
    end
  end

endmodule
